// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus: PC-source control and targets from ID, fetch address and IF/ID values back.
interface if_fetch_unit_if;
  logic [2:0]  PCSrc;
  logic        branch;
  logic        datahazard;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] jr_target;
  logic        irq_ext;
  logic [31:0] imem_addr;
  logic [31:0] PCplusout;
  logic        IRQout;

  modport master (
    output PCSrc, branch, datahazard, branch_target, jump_target, jr_target, irq_ext,
    input  imem_addr, PCplusout, IRQout
  );

  modport slave (
    input  PCSrc, branch, datahazard, branch_target, jump_target, jr_target, irq_ext,
    output imem_addr, PCplusout, IRQout
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC select in IF/ID priority order, latched IRQ.
// Define IRQ_SYNC_EN to pass irq_ext through a two-flop synchroniser (+2 cycles latency).
module if_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h8000_0000,
  parameter logic [31:0] ILLOP_VECTOR = 32'h8000_0004,
  parameter logic [31:0] XADR_VECTOR  = 32'h8000_0008
) (
  input logic            clk,
  input logic            reset,
  if_fetch_unit_if.slave bus
);

  logic [31:0] pc;
  logic [31:0] pc_plus;
  logic [31:0] pc_next;
  logic        irq_s;
  logic        irq_pending;
  logic        irq_accept;

`ifdef IRQ_SYNC_EN
  logic [1:0] irq_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) irq_sync <= 2'b00;
    else        irq_sync <= {irq_sync[0], bus.irq_ext};
  end

  assign irq_s = irq_sync[1];
`else
  assign irq_s = bus.irq_ext;
`endif

  // Bit 31 is the supervisor flag; the increment never carries into it.
  assign pc_plus = {pc[31], pc[30:0] + 31'd4};

  always_comb begin
    pc_next = pc_plus;
    unique case (bus.PCSrc)
      3'b000:  pc_next = bus.datahazard ? pc : pc_plus;
      3'b001:  pc_next = bus.branch ? bus.branch_target : pc_plus;
      3'b010:  pc_next = (bus.jump_target & 32'h7FFF_FFFF) | {pc[31], 31'd0};
      3'b011:  pc_next = {pc[31] & bus.jr_target[31], bus.jr_target[30:0]};
      3'b101:  pc_next = XADR_VECTOR;
      default: pc_next = ILLOP_VECTOR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc <= RESET_VECTOR;
    else        pc <= pc_next;
  end

  assign irq_accept = (bus.PCSrc == 3'b101);

  // Acceptance clears even if a new request arrives on the same edge; it re-latches next edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          irq_pending <= 1'b0;
    else if (irq_accept) irq_pending <= 1'b0;
    else if (irq_s)      irq_pending <= 1'b1;
  end

  assign bus.imem_addr = pc;
  assign bus.PCplusout = pc_plus;
  assign bus.IRQout    = irq_pending & ~pc[31];

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit; follows IRQ_SYNC_EN for interrupt latency.
module tb_if_fetch_unit;

`ifdef IRQ_SYNC_EN
  localparam int IRQ_LAT = 3;
`else
  localparam int IRQ_LAT = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;

  if_fetch_unit_if bus ();

  if_fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle; inputs are changed after this returns.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] src, input logic br, input logic dh);
    bus.PCSrc      = src;
    bus.branch     = br;
    bus.datahazard = dh;
  endtask

  task automatic jr_to(input logic [31:0] tgt);
    drive(3'b011, 1'b0, 1'b0);
    bus.jr_target = tgt;
    step();
  endtask

  task automatic test_reset();
    drive(3'b000, 1'b0, 1'b0);
    bus.branch_target = '0;
    bus.jump_target   = '0;
    bus.jr_target     = '0;
    bus.irq_ext       = 1'b0;
    reset = 1'b0;
    #12;
    total++;
    if (bus.imem_addr !== 32'h8000_0000) begin
      bad++; $display("FAIL reset_addr got=%h exp=80000000", bus.imem_addr);
    end
    total++;
    if (bus.PCplusout !== 32'h8000_0004) begin
      bad++; $display("FAIL reset_pcplus got=%h exp=80000004", bus.PCplusout);
    end
    total++;
    if (bus.IRQout !== 1'b0) begin
      bad++; $display("FAIL reset_irq got=%b exp=0", bus.IRQout);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  task automatic test_seq();
    logic [31:0] exp_pc [3] = '{32'h8000_0004, 32'h8000_0008, 32'h8000_000C};
    drive(3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (bus.imem_addr !== exp_pc[i]) begin
        bad++; $display("FAIL seq_addr[%0d] got=%h exp=%h", i, bus.imem_addr, exp_pc[i]);
      end
      total++;
      if (bus.PCplusout !== exp_pc[i] + 32'd4) begin
        bad++; $display("FAIL seq_pcplus[%0d] got=%h exp=%h", i, bus.PCplusout, exp_pc[i] + 32'd4);
      end
    end
  endtask

  task automatic test_stall();
    jr_to(32'h0000_0010);
    drive(3'b000, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (bus.imem_addr !== 32'h0000_0010) begin
        bad++; $display("FAIL stall_hold[%0d] got=%h exp=00000010", i, bus.imem_addr);
      end
    end
    total++;
    if (bus.PCplusout !== 32'h0000_0014) begin
      bad++; $display("FAIL stall_pcplus got=%h exp=00000014", bus.PCplusout);
    end
    drive(3'b001, 1'b1, 1'b1);
    bus.branch_target = 32'h0000_0100;
    step();
    total++;
    if (bus.imem_addr !== 32'h0000_0100) begin
      bad++; $display("FAIL stall_branch got=%h exp=00000100", bus.imem_addr);
    end
  endtask

  task automatic test_branch_jump_jr();
    jr_to(32'h0000_0020);
    drive(3'b001, 1'b0, 1'b0);
    step();
    total++;
    if (bus.imem_addr !== 32'h0000_0024) begin
      bad++; $display("FAIL branch_not_taken got=%h exp=00000024", bus.imem_addr);
    end
    jr_to(32'h8000_0040);
    total++;
    if (bus.imem_addr !== 32'h0000_0040) begin
      bad++; $display("FAIL jr_user got=%h exp=00000040", bus.imem_addr);
    end
    drive(3'b101, 1'b0, 1'b0);
    step();
    jr_to(32'h8000_0020);
    jr_to(32'h8000_0040);
    total++;
    if (bus.imem_addr !== 32'h8000_0040) begin
      bad++; $display("FAIL jr_super got=%h exp=80000040", bus.imem_addr);
    end
    // Jump keeps the mode bit, ignores the stall, and passes unaligned low bits.
    drive(3'b010, 1'b0, 1'b1);
    bus.jump_target = 32'h1234_5677;
    step();
    total++;
    if (bus.imem_addr !== 32'h9234_5677) begin
      bad++; $display("FAIL jump got=%h exp=92345677", bus.imem_addr);
    end
  endtask

  task automatic test_wrap_illop();
    jr_to(32'h7FFF_FFFC);
    total++;
    if (bus.PCplusout !== 32'h0000_0000) begin
      bad++; $display("FAIL wrap_user_pcplus got=%h exp=00000000", bus.PCplusout);
    end
    drive(3'b000, 1'b0, 1'b0);
    step();
    total++;
    if (bus.imem_addr !== 32'h0000_0000) begin
      bad++; $display("FAIL wrap_user got=%h exp=00000000", bus.imem_addr);
    end
    drive(3'b100, 1'b0, 1'b0);
    step();
    total++;
    if (bus.imem_addr !== 32'h8000_0004) begin
      bad++; $display("FAIL illop_100 got=%h exp=80000004", bus.imem_addr);
    end
    jr_to(32'hFFFF_FFFC);
    drive(3'b000, 1'b0, 1'b0);
    step();
    total++;
    if (bus.imem_addr !== 32'h8000_0000) begin
      bad++; $display("FAIL wrap_super got=%h exp=80000000", bus.imem_addr);
    end
    drive(3'b110, 1'b0, 1'b0);
    step();
    total++;
    if (bus.imem_addr !== 32'h8000_0004) begin
      bad++; $display("FAIL illop_110 got=%h exp=80000004", bus.imem_addr);
    end
    drive(3'b000, 1'b0, 1'b0);
    step();
    drive(3'b111, 1'b0, 1'b1);
    step();
    total++;
    if (bus.imem_addr !== 32'h8000_0004) begin
      bad++; $display("FAIL illop_111 got=%h exp=80000004", bus.imem_addr);
    end
  endtask

  task automatic test_irq();
    jr_to(32'h0000_0200);
    drive(3'b000, 1'b0, 1'b1);
    bus.irq_ext = 1'b1;
    for (int k = 1; k <= IRQ_LAT + 2; k++) begin
      step();
      bus.irq_ext = 1'b0;
      total++;
      if (bus.IRQout !== (k >= IRQ_LAT)) begin
        bad++; $display("FAIL irq_latency[%0d] got=%b exp=%b", k, bus.IRQout, k >= IRQ_LAT);
      end
    end
    total++;
    if (bus.imem_addr !== 32'h0000_0200) begin
      bad++; $display("FAIL irq_stall_hold got=%h exp=00000200", bus.imem_addr);
    end
    drive(3'b101, 1'b0, 1'b0);
    step();
    total++;
    if (bus.imem_addr !== 32'h8000_0008 || bus.IRQout !== 1'b0) begin
      bad++; $display("FAIL irq_accept got=%h/%b exp=80000008/0", bus.imem_addr, bus.IRQout);
    end
    jr_to(32'h0000_0300);
    total++;
    if (bus.IRQout !== 1'b0) begin
      bad++; $display("FAIL irq_cleared got=%b exp=0", bus.IRQout);
    end
    drive(3'b101, 1'b0, 1'b0);
    step();
    drive(3'b000, 1'b0, 1'b1);
    bus.irq_ext = 1'b1;
    for (int k = 1; k <= IRQ_LAT + 1; k++) begin
      step();
      bus.irq_ext = 1'b0;
      total++;
      if (bus.IRQout !== 1'b0) begin
        bad++; $display("FAIL irq_masked[%0d] got=%b exp=0", k, bus.IRQout);
      end
    end
    jr_to(32'h0000_0400);
    total++;
    if (bus.IRQout !== 1'b1) begin
      bad++; $display("FAIL irq_unmasked got=%b exp=1", bus.IRQout);
    end
  endtask

  task automatic test_reset_mid();
    jr_to(32'h0000_0050);
    total++;
    if (bus.imem_addr !== 32'h0000_0050 || bus.IRQout !== 1'b1) begin
      bad++; $display("FAIL pre_reset got=%h/%b exp=00000050/1", bus.imem_addr, bus.IRQout);
    end
    #1 reset = 1'b0;
    #1;
    total++;
    if (bus.imem_addr !== 32'h8000_0000 || bus.IRQout !== 1'b0) begin
      bad++; $display("FAIL async_reset got=%h/%b exp=80000000/0", bus.imem_addr, bus.IRQout);
    end
    @(negedge clk);
    reset = 1'b1;
    drive(3'b000, 1'b0, 1'b0);
    step();
    total++;
    if (bus.imem_addr !== 32'h8000_0004) begin
      bad++; $display("FAIL resume got=%h exp=80000004", bus.imem_addr);
    end
    jr_to(32'h0000_0060);
    total++;
    if (bus.IRQout !== 1'b0) begin
      bad++; $display("FAIL no_pending_after_reset got=%b exp=0", bus.IRQout);
    end
  endtask

  initial begin
    test_reset();
    test_seq();
    test_stall();
    test_branch_jump_jr();
    test_wrap_illop();
    test_irq();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage: the writer side of the IF/ID pipeline register.
- Holds the program counter, drives the instruction-memory address, and produces the PC+4 and IRQ values that IF/ID captures.
- Takes the PC-source select, branch flag and data-hazard stall with the same encoding and priority that IF/ID uses, so both stay in lockstep.
- Synchronises and latches the external interrupt request until it is accepted.

Parameters:
- RESET_VECTOR, 32'h80000000, PC value on reset (supervisor mode, PC[31]=1).
- ILLOP_VECTOR, 32'h80000004, target for PCSrc=3'b100 and the undefined encodings.
- XADR_VECTOR, 32'h80000008, interrupt handler target for PCSrc=3'b101.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- PCSrc  in  3  PC source select: 000 seq, 001 branch, 010 jump, 011 jr, 100 illop, 101 xadr, 110/111 undefined.
- branch  in  1  branch condition resolved true (meaningful with PCSrc=001).
- datahazard  in  1  load-use stall request.
- branch_target  in  32  computed branch target.
- jump_target  in  32  J/JAL target, already concatenated by ID.
- jr_target  in  32  register value for JR/JALR.
- irq_ext  in  1  external interrupt, asynchronous, level.
- imem_addr  out  32  instruction-memory address; equals the PC register.
- PCplusout  out  32  PC+4 of the current fetch; goes to IF/ID PCplusin.
- IRQout  out  1  qualified interrupt flag; goes to IF/ID IRQin.

Behaviour:
- Reset (reset=0, asynchronous): PC=RESET_VECTOR, sync flops=0, irq_pending=0.
  - Therefore imem_addr=32'h80000000, PCplusout=32'h80000004, IRQout=0.
  - Deasserting reset mid-operation resumes fetch at RESET_VECTOR on the next edge.
- PCplusout (combinational): {PC[31], PC[30:0]+31'd4}.
  - Low 31 bits wrap modulo 2^31; bit 31 is never changed by increment.
  - Example: 32'h7FFFFFFC -> 32'h00000000; 32'hFFFFFFFC -> 32'h80000000.
- Next-PC selection, evaluated each rising edge in this priority order:
  - PCSrc=000 and datahazard=1: PC holds.
  - PCSrc=000 and datahazard=0: PC <= PCplusout.
  - PCSrc=001: PC <= branch_target if branch=1, else PCplusout. Stall is ignored, matching IF/ID.
  - PCSrc=010: PC <= {PC[31], jump_target[30:0]}.
  - PCSrc=011: PC <= {PC[31] & jr_target[31], jr_target[30:0]}.
    - Supervisor mode may drop to user mode; user mode can never enter supervisor mode via JR.
  - PCSrc=100, 110 or 111: PC <= ILLOP_VECTOR.
  - PCSrc=101: PC <= XADR_VECTOR.
- Any non-zero PCSrc overrides datahazard.
- Branch/jump targets carry no alignment check; bits [1:0] pass through unchanged.
- Interrupt:
  - irq_s = synchronised irq_ext.
  - irq_pending sets on any edge with irq_s=1.
  - irq_pending clears on the edge where PCSrc=101 (interrupt accepted).
  - If clear and set coincide, clear wins for that edge; the request re-latches on the next edge if irq_s is still 1.
  - IRQout = irq_pending & ~PC[31] (combinational): masked in supervisor mode, but kept pending.
  - A pulse on irq_s of one cycle is retained until accepted.
- Stall with pending IRQ: IRQout stays asserted while PC holds.

Optional Feature:
- IRQ_SYNC_EN defined: irq_ext passes through two flip-flops (reset to 0) before irq_pending, adding 2 cycles of latency.
- Undefined: irq_s = irq_ext directly; irq_pending samples it on the same edge. Use only when irq_ext is already synchronous to clk.

Test Plan:
- Reset then 3 cycles with PCSrc=000, datahazard=0 -> imem_addr 80000000, 80000004, 80000008, 8000000C; PCplusout always imem_addr+4.
- PC=00000010, datahazard=1 for 2 cycles -> PC stays 00000010. Then PCSrc=001, branch=1, branch_target=00000100 with datahazard=1 -> PC=00000100.
- PC=00000020, PCSrc=001, branch=0 -> PC=00000024. PCSrc=011, jr_target=80000040 from user mode -> PC=00000040. Same from PC=80000020 -> PC=80000040.
- PC=7FFFFFFC, seq fetch -> PC=00000000. PC=FFFFFFFC -> PC=80000000. PCSrc=110 -> PC=80000004.
- User-mode PC, irq_ext 1-cycle pulse (IRQ_SYNC_EN defined) -> IRQout=1 three edges later and stays 1. PCSrc=101 -> PC=80000008, IRQout=0. Pulse in supervisor mode -> IRQout stays 0 until a JR to a user address, then goes to 1.
- Assert reset mid-stream at PC=00000050 with irq_pending=1 -> immediately PC=80000000, IRQout=0. No pending IRQ after release.
